// File: rtl/obc_dft_pkg.sv
// obc_dft_pkg: shared sizes and types for the OBC DFT bit-serial stage
package obc_dft_pkg;
    localparam int N_PTS      = 16;
    localparam int DFT_DATA_W = 8;
    localparam int DFT_ROM_W  = 32;
    localparam int DFT_ACC_W  = 48;
    typedef enum logic [1:0] {IDLE, SLICE, DONE} state_t;
    typedef logic [N_PTS-1:0] slice_t;
endpackage

// File: rtl/obc_slice_mux.sv
// obc_slice_mux: holds the captured sample block and presents one bit-slice per cycle
module obc_slice_mux
    import obc_dft_pkg::*;
#(
    parameter int DATA_W = DFT_DATA_W,
    parameter int IDX_W  = $clog2(DFT_DATA_W)
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic [N_PTS*DATA_W-1:0] samples,
    input  logic                    active,
    input  logic [IDX_W-1:0]        bit_idx,
    output slice_t                  x_bits,
    output logic                    m
);
    logic [DATA_W-1:0] regs [N_PTS];

    always_ff @(posedge clk) begin
        if (load)
            for (int k = 0; k < N_PTS; k++) regs[k] <= samples[k*DATA_W +: DATA_W];
    end

    always_comb begin
        x_bits = '0;
        for (int k = 0; k < N_PTS; k++) x_bits[k] = active & regs[k][bit_idx];
        m = active && (bit_idx == IDX_W'(DATA_W-1));
    end
endmodule

// File: rtl/obc_bit_serial_accum.sv
// obc_bit_serial_accum: sequences bit-slices MSB-first into the OBC ROM stage and
// shift-accumulates the returned partial sums into one DFT output word
module obc_bit_serial_accum
    import obc_dft_pkg::*;
#(
    parameter int                      DATA_W = DFT_DATA_W,
    parameter int                      ROM_W  = DFT_ROM_W,
    parameter int                      ACC_W  = DFT_ACC_W,
    parameter logic signed [ACC_W-1:0] OFFSET = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_PTS*DATA_W-1:0] samples,
    output slice_t                  x_bits,
    output logic                    m,
    input  logic [ROM_W-1:0]        romout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        result
);
    localparam int IDX_W = $clog2(DATA_W);

    state_t                  state;
    logic [IDX_W-1:0]        bit_idx;
    logic signed [ACC_W-1:0] acc, acc_next, rom_ext;

    // ROM stage already negates the sign slice, so every slice is simply added
    assign rom_ext  = ACC_W'($signed(romout));
    assign acc_next = (acc <<< 1) + rom_ext;

    obc_slice_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_mux (
        .clk(clk),
        .load(state == IDLE && in_valid),
        .samples(samples),
        .active(state == SLICE),
        .bit_idx(bit_idx),
        .x_bits(x_bits),
        .m(m)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
            bit_idx   <= IDX_W'(DATA_W-1);
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state    <= SLICE;
                    in_ready <= 1'b0;
                    acc      <= '0;
                    bit_idx  <= IDX_W'(DATA_W-1);
                end
                SLICE: begin
                    acc     <= acc_next;
                    bit_idx <= bit_idx - 1'b1;
                    if (bit_idx == '0) begin
                        state     <= DONE;
                        result    <= acc_next + OFFSET;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_obc_bit_serial_accum.sv
// tb_obc_bit_serial_accum: scoreboard bench with behavioural ROM stubs; a second
// instance with OFFSET=100 runs in lockstep on the same stimulus
module tb_obc_bit_serial_accum;
    import obc_dft_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst, in_valid, out_ready;
    logic [N_PTS*DFT_DATA_W-1:0] samples;
    logic                        in_ready, in_ready_o, m, m_o, out_valid, out_valid_o;
    slice_t                      x_bits, x_bits_o;
    logic [DFT_ROM_W-1:0]        romout, romout_o;
    logic [DFT_ACC_W-1:0]        result, result_o;
    logic signed [DFT_ACC_W-1:0] e;
    logic signed [DFT_ACC_W-1:0] exp_q [$];
    int mode;
    int errors = 0;
    int checks = 0;

    obc_bit_serial_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .samples(samples),
        .x_bits(x_bits), .m(m), .romout(romout), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    obc_bit_serial_accum #(.OFFSET(48'sd100)) dut_o (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o), .samples(samples),
        .x_bits(x_bits_o), .m(m_o), .romout(romout_o), .out_valid(out_valid_o),
        .out_ready(out_ready), .result(result_o)
    );

    // mode 0: m ? -5 : 3; mode 1: x_bits[0]; mode 2: weighted popcount (k+1), negated on sign slice
    function automatic logic [DFT_ROM_W-1:0] stub(input int md, input slice_t x, input logic mm);
        int s = 0;
        if (md == 0) return mm ? 32'(-5) : 32'(3);
        if (md == 1) return {31'b0, x[0]};
        for (int k = 0; k < N_PTS; k++) s += x[k] ? k + 1 : 0;
        return mm ? 32'(-s) : 32'(s);
    endfunction

    function automatic logic signed [DFT_ACC_W-1:0] model(input int md, input logic [N_PTS*DFT_DATA_W-1:0] s);
        logic signed [DFT_ACC_W-1:0] r = '0;
        if (md == 0) r = -5 * 128 + 3 * 127;
        else if (md == 1) r = DFT_ACC_W'(s[7:0]);
        else for (int k = 0; k < N_PTS; k++) r += (k + 1) * $signed(s[k*DFT_DATA_W +: DFT_DATA_W]);
        return r;
    endfunction

    always_comb romout   = stub(mode, x_bits, m);
    always_comb romout_o = stub(mode, x_bits_o, m_o);

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_PTS*DFT_DATA_W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // inputs settle 1 time unit after posedge, so the negedge sees what the next posedge uses
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(model(mode, samples));
            if (out_valid && out_ready) begin
                chk("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("result", $signed(result), e);
                    chk("result_off", $signed(result_o), e + 100);
                    chk("ov_off", out_valid_o, 1);
                end
            end
        end
    end

    task automatic send(input logic [N_PTS*DFT_DATA_W-1:0] s, input int hold,
                        input int intrude_at, input int rst_at, input bit chain);
        int lat;
        int mc;
        chk("in_ready", in_ready, 1);
        samples  = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        mc  = 0;
        chk("m_first", m, 1);
        while (!out_valid && lat < 40) begin
            if (m) mc++;
            if (lat == intrude_at) begin
                samples  = ~s;
                in_valid = 1'b1;
                chk("busy_ready", in_ready, 0);
            end
            if (lat == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                exp_q.delete();
                chk("rst_ov", out_valid, 0);
                chk("rst_ready", in_ready, 1);
                chk("rst_x", x_bits, 0);
                chk("rst_m", m, 0);
                return;
            end
            tick();
            in_valid = 1'b0;
            lat++;
        end
        chk("latency", lat, 9);
        chk("m_count", mc, 1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", $signed(result), exp_q[0]);
            tick();
        end
        if (!chain) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("done_exit", out_valid, 0);
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; samples = '0; mode = 0;
        repeat (3) tick();
        chk("reset_ready", in_ready, 1);
        chk("reset_ready_off", in_ready_o, 1);
        chk("reset_ov", out_valid, 0);
        chk("reset_result", $signed(result), 0);
        chk("reset_x", x_bits, 0);
        chk("reset_m", m, 0);
        rst = 1'b0;
        tick();

        mode = 0;
        send(rnd(), 0, 0, 0, 0);
        send(rnd(), 5, 0, 0, 0);
        mode = 1;
        send({120'b0, 8'h80}, 0, 0, 0, 0);
        mode = 2;
        repeat (3) send(rnd(), 0, 0, 0, 0);
        send(rnd(), 0, 3, 0, 0);
        send(rnd(), 0, 0, 4, 0);
        send(rnd(), 0, 0, 0, 0);

        // back-to-back: accept next block in the same cycle the result is taken
        send(rnd(), 1, 0, 0, 1);
        samples   = rnd();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_accept", in_ready, 0);
        chk("b2b_m", m, 1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("b2b_latency", lat, 9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        chk("q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
